// File: rtl/multi_channel_fifo.sv
// Single-clock FIFO with CHANNELS independent queues sharing one write and one read port.
// Optional MULTI_CHANNEL_FIFO_ALMOST_FLAGS_EN adds ALMOST_MARGIN and almost_full/almost_empty.
module multi_channel_fifo #(
    parameter int CAPACITY  = 3,
    parameter int BIT_WIDTH = 8,
    parameter int CHANNELS  = 2,
`ifdef MULTI_CHANNEL_FIFO_ALMOST_FLAGS_EN
    parameter int ALMOST_MARGIN = 1,
`endif
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int POP_W = $clog2(CAPACITY + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [BIT_WIDTH-1:0]      data_in,
    input  logic                      enqueue,
    input  logic [CH_W-1:0]           enqueue_channel,
    input  logic                      dequeue,
    input  logic [CH_W-1:0]           dequeue_channel,
    input  logic [CHANNELS-1:0]       flush,
    output logic [BIT_WIDTH-1:0]      data_out,
    output logic                      data_out_valid,
    output logic [CHANNELS*POP_W-1:0] population,
    output logic [CHANNELS-1:0]       full,
    output logic [CHANNELS-1:0]       empty,
    output logic                      overflow,
`ifdef MULTI_CHANNEL_FIFO_ALMOST_FLAGS_EN
    output logic                      underflow,
    output logic [CHANNELS-1:0]       almost_full,
    output logic [CHANNELS-1:0]       almost_empty
`else
    output logic                      underflow
`endif
);

    localparam int PTR_W = $clog2(CAPACITY);
    localparam logic [CH_W:0]         CH_LIMIT = CHANNELS[CH_W:0];
    localparam logic [CHANNELS-1:0]   CH_ONE   = CHANNELS'(1'b1);
    localparam logic [POP_W-1:0]      POP_FULL = POP_W'(CAPACITY);
    localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(CAPACITY - 1);

    logic [BIT_WIDTH-1:0] buf_r  [CHANNELS][CAPACITY];
    logic [PTR_W-1:0]     wptr_r [CHANNELS];
    logic [PTR_W-1:0]     rptr_r [CHANNELS];
    logic [POP_W-1:0]     pop_r  [CHANNELS];

    logic                 enq_in_range_s;
    logic                 deq_in_range_s;
    logic [CHANNELS-1:0]  enq_sel_s;
    logic [CHANNELS-1:0]  deq_sel_s;
    logic [CHANNELS-1:0]  enq_acc_s;
    logic [CHANNELS-1:0]  deq_acc_s;
    logic                 ovf_evt_s;
    logic                 udf_evt_s;
    logic [BIT_WIDTH-1:0] rd_data_s;

    // Capacity is not necessarily a power of two, so wrap by explicit compare.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Request decode, per-channel acceptance and error events.
    always_comb begin
        enq_in_range_s = ({1'b0, enqueue_channel} < CH_LIMIT);
        deq_in_range_s = ({1'b0, dequeue_channel} < CH_LIMIT);
        enq_sel_s = (enqueue && enq_in_range_s) ? (CH_ONE << enqueue_channel) : '0;
        deq_sel_s = (dequeue && deq_in_range_s) ? (CH_ONE << dequeue_channel) : '0;
        enq_acc_s = '0;
        deq_acc_s = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            deq_acc_s[c] = deq_sel_s[c] && !flush[c] && (pop_r[c] != '0);
            // A full queue still accepts a write when the same cycle frees a slot.
            enq_acc_s[c] = enq_sel_s[c] && !flush[c] && ((pop_r[c] != POP_FULL) || deq_acc_s[c]);
        end
        ovf_evt_s = (enqueue && !enq_in_range_s) || (|(enq_sel_s & ~flush & ~enq_acc_s));
        udf_evt_s = (dequeue && !deq_in_range_s) || (|(deq_sel_s & ~flush & ~deq_acc_s));
        if (deq_in_range_s) begin
            rd_data_s = buf_r[dequeue_channel][rptr_r[dequeue_channel]];
        end else begin
            rd_data_s = '0;
        end
    end

    // Queue storage; contents are don't-care after reset so no reset term.
    always_ff @(posedge clock) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (!reset && enq_acc_s[c]) begin
                buf_r[c][wptr_r[c]] <= data_in;
            end
        end
    end

    // Pointers, populations, read data and sticky error flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wptr_r[c] <= '0;
                rptr_r[c] <= '0;
                pop_r[c]  <= '0;
            end
            data_out       <= '0;
            data_out_valid <= 1'b0;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (flush[c]) begin
                    wptr_r[c] <= '0;
                    rptr_r[c] <= '0;
                    pop_r[c]  <= '0;
                end else begin
                    if (enq_acc_s[c]) begin
                        wptr_r[c] <= ptr_next(wptr_r[c]);
                    end
                    if (deq_acc_s[c]) begin
                        rptr_r[c] <= ptr_next(rptr_r[c]);
                    end
                    if (enq_acc_s[c] && !deq_acc_s[c]) begin
                        pop_r[c] <= pop_r[c] + POP_W'(1);
                    end else if (deq_acc_s[c] && !enq_acc_s[c]) begin
                        pop_r[c] <= pop_r[c] - POP_W'(1);
                    end
                end
            end
            data_out_valid <= |deq_acc_s;
            if (|deq_acc_s) begin
                data_out <= rd_data_s;
            end
            if (ovf_evt_s) begin
                overflow <= 1'b1;
            end
            if (udf_evt_s) begin
                underflow <= 1'b1;
            end
        end
    end

    // Status views derived from the registered populations.
    always_comb begin
        population = '0;
        full       = '0;
        empty      = '0;
`ifdef MULTI_CHANNEL_FIFO_ALMOST_FLAGS_EN
        almost_full  = '0;
        almost_empty = '0;
`endif
        for (int c = 0; c < CHANNELS; c++) begin
            population[c*POP_W +: POP_W] = pop_r[c];
            full[c]  = (pop_r[c] == POP_FULL);
            empty[c] = (pop_r[c] == '0);
`ifdef MULTI_CHANNEL_FIFO_ALMOST_FLAGS_EN
            almost_full[c]  = (int'(pop_r[c]) >= (CAPACITY - ALMOST_MARGIN));
            almost_empty[c] = (int'(pop_r[c]) <= ALMOST_MARGIN);
`endif
        end
    end

endmodule

// File: doc/multi_channel_fifo.md
Name: multi_channel_fifo

Overview:
Single-clock, multi-channel FIFO; parametrised successor to the team's two-clock FIFO, generalised to CHANNELS independent queues of CAPACITY entries each.
- One write port and one read port, each steered by a channel index.
- Per-channel flush, population, full and empty.
- Sticky overflow and underflow error flags.
- Sits between packet sources and a shared consumer that services channels by index.

Parameters:
CAPACITY, 3, entries per channel; any value >= 2, not required to be a power of two.
BIT_WIDTH, 8, data word width.
CHANNELS, 2, number of independent queues; >= 1.
(derived) CH_W = max(1, $clog2(CHANNELS)); POP_W = $clog2(CAPACITY+1).

Ports:
clock  input  1  single clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
data_in  input  BIT_WIDTH  write data.
enqueue  input  1  write request.
enqueue_channel  input  CH_W  target channel for write.
dequeue  input  1  read request.
dequeue_channel  input  CH_W  source channel for read.
flush  input  CHANNELS  per-channel clear mask.
data_out  output  BIT_WIDTH  registered read data.
data_out_valid  output  1  data_out updated by an accepted dequeue on the previous edge.
population  output  CHANNELS*POP_W  packed per-channel entry counts; channel c at bits [c*POP_W +: POP_W].
full  output  CHANNELS  population == CAPACITY.
empty  output  CHANNELS  population == 0.
overflow  output  1  sticky: an enqueue was rejected.
underflow  output  1  sticky: a dequeue was rejected.

Behaviour:
- Reset (synchronous; dominates every other input), next-edge values:
  - all read/write pointers and populations 0; empty all 1; full all 0.
  - data_out 0; data_out_valid 0; overflow 0; underflow 0.
  - buffer contents don't-care.
- Storage: CHANNELS x CAPACITY array. Per-channel write pointer, read pointer and population. Pointers wrap CAPACITY-1 -> 0 (explicit compare, not a power-of-two mask).
- Out-of-range channel index (>= CHANNELS): request ignored, sets the corresponding error flag.
- Enqueue on channel c accepted when !flush[c] and either:
  - !full[c], or
  - a dequeue on c is accepted in the same cycle (full-queue pass-through).
  On accept: write at wptr[c], advance wptr[c].
- Dequeue on channel c accepted when !flush[c] and !empty[c]. No same-cycle bypass: if c is empty, a simultaneous enqueue on c is accepted but the dequeue is rejected.
  On accept: data_out <= buffer[c][rptr[c]], advance rptr[c], data_out_valid <= 1.
  Otherwise data_out_valid <= 0 and data_out holds its value.
  Read latency: 1 edge.
- Population update per channel: +1 for enqueue only, -1 for dequeue only, unchanged for both or neither.
- Flush:
  - flush[c] sets pointers and population of c to 0 on that edge.
  - Enqueue/dequeue targeting c in that cycle are dropped without setting error flags.
  - Other channels are unaffected.
- Error flags:
  - overflow set on a rejected enqueue (full, no pass-through) or a bad enqueue index.
  - underflow set on a rejected dequeue or a bad dequeue index.
  - Both stay set until reset.
- full, empty and population are combinational from registered population (reflect state after the last edge).
- Reset asserted mid-stream discards all queued data; requests in the reset cycle have no effect.

Optional Feature:
MULTI_CHANNEL_FIFO_ALMOST_FLAGS_EN
- Defined:
  - Adds parameter ALMOST_MARGIN (default 1).
  - Adds outputs almost_full[CHANNELS] (population >= CAPACITY-ALMOST_MARGIN) and almost_empty[CHANNELS] (population <= ALMOST_MARGIN).
  - Both are combinational from population. After reset: almost_empty all 1, almost_full all 0.
- Undefined: the parameter and both ports are absent; all other behaviour is identical.

Test Plan:
- CHANNELS=2, CAPACITY=3, BIT_WIDTH=8: reset, then enqueue 100,150,200 on ch0.
  -> population ch0 = 3, full[0]=1, empty[1]=1.
  -> a 4th enqueue (250) sets overflow=1; ch0 contents unchanged.
- From full ch0: enqueue 250 plus dequeue ch0 in the same cycle.
  -> data_out=100, data_out_valid=1 next edge; population stays 3.
  -> subsequent dequeues return 150, 200, 250 (wrap-around verified); overflow not newly set.
- Interleave: ch0 gets 10,11 and ch1 gets 20. Dequeue ch1, ch0, ch0.
  -> outputs 20, 10, 11.
  -> then dequeue empty ch0 sets underflow=1 with data_out_valid=0 and data_out holding 11.
- Empty ch1: simultaneous enqueue 55 and dequeue ch1.
  -> dequeue rejected (underflow=1), population ch1 = 1.
  -> next dequeue returns 55.
- Fill ch0 with 2 entries, then flush=2'b01 together with enqueue ch0.
  -> population ch0 = 0, empty[0]=1, no error flag.
  -> ch1 contents preserved.
  -> then assert reset mid-stream: all outputs return to reset values on the next edge.
- With MULTI_CHANNEL_FIFO_ALMOST_FLAGS_EN defined, ALMOST_MARGIN=1, CAPACITY=3:
  -> populations 0,1,2,3 give almost_empty 1,1,0,0 and almost_full 0,0,1,1.
